// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha block engine: sigma words, FSM and step encodings,
// and the quarter-round index tables for column and diagonal rounds.
package chacha_pkg;

  localparam logic [31:0] SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL, ST_OUT} state_t;

  // bit 0 set marks the b/c half of a quarter round
  typedef enum logic [1:0] {OP_AD0, OP_BC0, OP_AD1, OP_BC1} step_op_t;

  // [quarter-round][a,b,c,d]
  localparam logic [3:0] QR_COL [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam logic [3:0] QR_DIAG [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_block_core_if.sv
// Load / keystream handshake bundle of chacha_block_core.
// in_next exists only when CHACHA_CTR_AUTOINC_EN is defined.
interface chacha_block_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_key;
  logic [95:0]  in_nonce;
  logic [31:0]  in_ctr;
`ifdef CHACHA_CTR_AUTOINC_EN
  logic         in_next;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_block;
  logic         busy;

`ifdef CHACHA_CTR_AUTOINC_EN
  modport master (output in_valid, in_key, in_nonce, in_ctr, in_next, out_ready,
                  input in_ready, out_valid, out_block, busy);
  modport slave  (input in_valid, in_key, in_nonce, in_ctr, in_next, out_ready,
                  output in_ready, out_valid, out_block, busy);
`else
  modport master (output in_valid, in_key, in_nonce, in_ctr, out_ready,
                  input in_ready, out_valid, out_block, busy);
  modport slave  (input in_valid, in_key, in_nonce, in_ctr, out_ready,
                  output in_ready, out_valid, out_block, busy);
`endif
endinterface

// File: rtl/chacha_ise.sv
// Combinational packed quarter-round half-step: rs1={a,d}, rs2={b,c}.
// ad steps return {a',d'}, bc steps return {b',c'}.
module chacha_ise
  import chacha_pkg::*;
(
  input  step_op_t    op,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  output logic [63:0] rd
);
  logic [31:0] a, b, c, d, sum, mix;

  assign {a, d} = rs1;
  assign {b, c} = rs2;

  always_comb begin
    sum = 32'd0;
    mix = 32'd0;
    case (op)
      OP_AD0:  begin sum = a + b; mix = rotl(d ^ sum, 16); end
      OP_BC0:  begin sum = c + d; mix = rotl(b ^ sum, 12); end
      OP_AD1:  begin sum = a + b; mix = rotl(d ^ sum, 8);  end
      default: begin sum = c + d; mix = rotl(b ^ sum, 7);  end
    endcase
  end

  assign rd = op[0] ? {mix, sum} : {sum, mix};
endmodule

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block engine: four parallel half-step units, feed-forward, one 512-bit block out.
// Optional CHACHA_CTR_AUTOINC_EN adds in_next to rerun the retained key/nonce with ctr+1.
//
// state    | meaning
// ST_IDLE  | waiting for a load (in_ready=1)
// ST_ROUND | one half-step of all four quarter rounds per cycle
// ST_FINAL | feed-forward add of the initial state
// ST_OUT   | block presented until out_ready
module chacha_block_core
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input logic                g_clk,
  input logic                g_rst,
  chacha_block_core_if.slave bus
);
  localparam int RW = $clog2(ROUNDS);

  state_t        state;
  step_op_t      step;
  logic [RW-1:0] rnd;
  logic [31:0]   x    [16];
  logic [31:0]   init [16];
  logic [31:0]   ld   [16];
  logic          in_ready_q, out_valid_q, busy_q;
  logic          start;
  logic [3:0]    qa [4], qb [4], qc [4], qd [4];
  logic [63:0]   rs1 [4], rs2 [4], rd [4];

`ifdef CHACHA_CTR_AUTOINC_EN
  logic have_blk;
  logic reload;
  assign reload = !bus.in_valid && bus.in_next && have_blk;
  assign start  = bus.in_valid || reload;
`else
  assign start  = bus.in_valid;
`endif

  // init[] doubles as the retained key/ctr/nonce for counter auto-increment
  always_comb begin
    for (int i = 0; i < 4; i++) ld[i] = SIGMA[i];
    for (int i = 0; i < 8; i++) ld[4+i] = bus.in_key[32*i +: 32];
    ld[12] = bus.in_ctr;
    for (int j = 0; j < 3; j++) ld[13+j] = bus.in_nonce[32*j +: 32];
`ifdef CHACHA_CTR_AUTOINC_EN
    if (reload) begin
      for (int i = 4; i < 16; i++) ld[i] = init[i];
      ld[12] = init[12] + 32'd1;
    end
`endif
  end

  always_comb begin
    for (int q = 0; q < 4; q++) begin
      qa[q] = rnd[0] ? QR_DIAG[q][0] : QR_COL[q][0];
      qb[q] = rnd[0] ? QR_DIAG[q][1] : QR_COL[q][1];
      qc[q] = rnd[0] ? QR_DIAG[q][2] : QR_COL[q][2];
      qd[q] = rnd[0] ? QR_DIAG[q][3] : QR_COL[q][3];
    end
  end

  for (genvar q = 0; q < 4; q++) begin : g_qr
    assign rs1[q] = {x[qa[q]], x[qd[q]]};
    assign rs2[q] = {x[qb[q]], x[qc[q]]};
    chacha_ise u_ise (.op(step), .rs1(rs1[q]), .rs2(rs2[q]), .rd(rd[q]));
  end

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      state       <= ST_IDLE;
      step        <= OP_AD0;
      rnd         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        x[i]    <= 32'd0;
        init[i] <= 32'd0;
      end
`ifdef CHACHA_CTR_AUTOINC_EN
      have_blk    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          x          <= ld;
          init       <= ld;
          rnd        <= '0;
          step       <= OP_AD0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          state      <= ST_ROUND;
        end
        ST_ROUND: begin
          for (int q = 0; q < 4; q++) begin
            if (step[0]) begin
              x[qb[q]] <= rd[q][63:32];
              x[qc[q]] <= rd[q][31:0];
            end else begin
              x[qa[q]] <= rd[q][63:32];
              x[qd[q]] <= rd[q][31:0];
            end
          end
          step <= step_op_t'(step + 2'd1);
          if (step == OP_BC1) begin
            rnd <= rnd + 1'b1;
            if (rnd == RW'(ROUNDS - 1)) state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          for (int i = 0; i < 16; i++) x[i] <= x[i] + init[i];
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= ST_OUT;
        end
        default: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= ST_IDLE;
`ifdef CHACHA_CTR_AUTOINC_EN
          have_blk    <= 1'b1;
`endif
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  for (genvar i = 0; i < 16; i++) begin : g_out
    assign bus.out_block[32*i +: 32] = x[i];
  end
endmodule

// File: tb/tb_chacha_block_core.sv
// Self-checking bench for chacha_block_core: vector table against an RFC-style block model,
// plus backpressure, ignored-load, mid-run reset and (CHACHA_CTR_AUTOINC_EN) counter sequences.
module tb_chacha_block_core;
  localparam int ROUNDS  = 20;
  localparam int LATENCY = 4 * ROUNDS + 2;
  localparam int NVEC    = 6;

  logic g_clk = 1'b0;
  logic g_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  chacha_block_core_if bus ();
  chacha_block_core #(.ROUNDS(ROUNDS)) dut (.g_clk(g_clk), .g_rst(g_rst), .bus(bus));

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
    logic [511:0] exp;
  } vec_t;

  vec_t         vecs [NVEC];
  logic [255:0] rfc_key;
  logic [95:0]  rfc_nonce;
  logic [511:0] rfc_exp;

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
    a = a + b; d = rol(d ^ a, 16);
    c = c + d; b = rol(b ^ c, 12);
    a = a + b; d = rol(d ^ a, 8);
    c = c + d; b = rol(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // Straight block function: double rounds on a 16-word array, then feed-forward.
  function automatic logic [511:0] ref_block(input logic [255:0] key, input logic [95:0] nonce,
                                             input logic [31:0] ctr);
    logic [31:0]  s [16];
    logic [31:0]  w [16];
    logic [511:0] r;
    s[0] = "expa"; s[1] = "nd 3"; s[2] = "2-by"; s[3] = "te k";
    s[0] = {s[0][7:0], s[0][15:8], s[0][23:16], s[0][31:24]};
    s[1] = {s[1][7:0], s[1][15:8], s[1][23:16], s[1][31:24]};
    s[2] = {s[2][7:0], s[2][15:8], s[2][23:16], s[2][31:24]};
    s[3] = {s[3][7:0], s[3][15:8], s[3][23:16], s[3][31:24]};
    for (int i = 0; i < 8; i++) s[4+i] = key[32*i +: 32];
    s[12] = ctr;
    for (int j = 0; j < 3; j++) s[13+j] = nonce[32*j +: 32];
    w = s;
    for (int dr = 0; dr < ROUNDS / 2; dr++) begin
      {w[0], w[4], w[8],  w[12]} = qr(w[0], w[4], w[8],  w[12]);
      {w[1], w[5], w[9],  w[13]} = qr(w[1], w[5], w[9],  w[13]);
      {w[2], w[6], w[10], w[14]} = qr(w[2], w[6], w[10], w[14]);
      {w[3], w[7], w[11], w[15]} = qr(w[3], w[7], w[11], w[15]);
      {w[0], w[5], w[10], w[15]} = qr(w[0], w[5], w[10], w[15]);
      {w[1], w[6], w[11], w[12]} = qr(w[1], w[6], w[11], w[12]);
      {w[2], w[7], w[8],  w[13]} = qr(w[2], w[7], w[8],  w[13]);
      {w[3], w[4], w[9],  w[14]} = qr(w[3], w[4], w[9],  w[14]);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i] + s[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    @(negedge g_clk);
    bus.in_key   = k;
    bus.in_nonce = n;
    bus.in_ctr   = c;
    bus.in_valid = 1'b1;
    @(posedge g_clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // edges+1 = clock edges from the handshake edge to the first edge that samples out_valid high
  task automatic wait_out(output int edges);
    edges = 0;
    while (!bus.out_valid && edges < LATENCY + 20) begin
      @(posedge g_clk);
      #1 edges++;
    end
  endtask

  task automatic consume(input string tag);
    @(negedge g_clk);
    bus.out_ready = 1'b1;
    @(posedge g_clk);
    #1 bus.out_ready = 1'b0;
    check({tag, "_in_ready_after"}, bus.in_ready, 1'b1);
    check({tag, "_out_valid_after"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    int edges;
    bus.in_valid  = 1'b0;
    bus.in_key    = '0;
    bus.in_nonce  = '0;
    bus.in_ctr    = '0;
    bus.out_ready = 1'b0;
`ifdef CHACHA_CTR_AUTOINC_EN
    bus.in_next   = 1'b0;
`endif

    for (int i = 0; i < 8; i++)
      rfc_key[32*i +: 32] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
    rfc_exp   = ref_block(rfc_key, rfc_nonce, 32'd1);

    vecs[0].key = rfc_key; vecs[0].nonce = rfc_nonce; vecs[0].ctr = 32'd1;
    vecs[1].key = '0;      vecs[1].nonce = '0;        vecs[1].ctr = 32'd0;
    for (int v = 2; v < NVEC; v++) begin
      for (int i = 0; i < 8; i++) vecs[v].key[32*i +: 32] = $urandom;
      for (int j = 0; j < 3; j++) vecs[v].nonce[32*j +: 32] = $urandom;
      vecs[v].ctr = $urandom;
    end
    vecs[NVEC-1].ctr = 32'hffffffff;
    for (int v = 0; v < NVEC; v++) vecs[v].exp = ref_block(vecs[v].key, vecs[v].nonce, vecs[v].ctr);

    repeat (3) @(posedge g_clk);
    @(negedge g_clk) g_rst = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_out_block", bus.out_block, '0);

`ifdef CHACHA_CTR_AUTOINC_EN
    @(negedge g_clk) bus.in_next = 1'b1;
    @(posedge g_clk);
    #1 bus.in_next = 1'b0;
    check("next_before_load_busy", bus.busy, 1'b0);
`endif

    for (int v = 0; v < NVEC; v++) begin
      load(vecs[v].key, vecs[v].nonce, vecs[v].ctr);
      check($sformatf("vec%0d_busy", v), bus.busy, 1'b1);
      check($sformatf("vec%0d_in_ready_busy", v), bus.in_ready, 1'b0);
      wait_out(edges);
      check($sformatf("vec%0d_latency", v), 512'(edges + 1), 512'(LATENCY));
      check($sformatf("vec%0d_block", v), bus.out_block, vecs[v].exp);
      consume($sformatf("vec%0d", v));
    end

    // RFC vector with output backpressure
    load(rfc_key, rfc_nonce, 32'd1);
    wait_out(edges);
    check("rfc_latency", 512'(edges + 1), 512'(LATENCY));
    check("rfc_word0", bus.out_block[31:0], 32'he4e7f110);
    check("rfc_word15", bus.out_block[511:480], 32'h4e3c50a2);
    check("rfc_block", bus.out_block, rfc_exp);
    for (int c = 0; c < 10; c++) begin
      @(posedge g_clk);
      #1;
      check($sformatf("bp%0d_block", c), bus.out_block, rfc_exp);
      check($sformatf("bp%0d_in_ready", c), bus.in_ready, 1'b0);
      check($sformatf("bp%0d_out_valid", c), bus.out_valid, 1'b1);
    end
    consume("bp");

    // in_valid pulsed mid-run with other inputs must not disturb the block
    load(rfc_key, rfc_nonce, 32'd1);
    repeat (20) @(posedge g_clk);
    @(negedge g_clk);
    bus.in_key   = vecs[2].key;
    bus.in_nonce = vecs[2].nonce;
    bus.in_ctr   = vecs[2].ctr;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge g_clk);
    bus.in_valid = 1'b0;
    wait_out(edges);
    check("ign_out_valid", bus.out_valid, 1'b1);
    check("ign_block", bus.out_block, rfc_exp);
    consume("ign");

    // reset after 40 steps, then a clean load
    load(vecs[3].key, vecs[3].nonce, vecs[3].ctr);
    repeat (40) @(posedge g_clk);
    #1 g_rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    @(negedge g_clk) g_rst = 1'b0;
    load(vecs[4].key, vecs[4].nonce, vecs[4].ctr);
    wait_out(edges);
    check("midrst_latency", 512'(edges + 1), 512'(LATENCY));
    check("midrst_block", bus.out_block, vecs[4].exp);
    consume("midrst");

`ifdef CHACHA_CTR_AUTOINC_EN
    load(rfc_key, rfc_nonce, 32'd1);
    wait_out(edges);
    check("inc_base_block", bus.out_block, rfc_exp);
    consume("inc_base");
    @(negedge g_clk) bus.in_next = 1'b1;
    @(posedge g_clk);
    #1 bus.in_next = 1'b0;
    check("inc_busy", bus.busy, 1'b1);
    wait_out(edges);
    check("inc_latency", 512'(edges + 1), 512'(LATENCY));
    check("inc_block", bus.out_block, ref_block(rfc_key, rfc_nonce, 32'd2));
    consume("inc");

    load(vecs[NVEC-1].key, vecs[NVEC-1].nonce, 32'hffffffff);
    wait_out(edges);
    check("wrap_base_block", bus.out_block, vecs[NVEC-1].exp);
    consume("wrap_base");
    @(negedge g_clk) bus.in_next = 1'b1;
    @(posedge g_clk);
    #1 bus.in_next = 1'b0;
    wait_out(edges);
    check("wrap_block", bus.out_block, ref_block(vecs[NVEC-1].key, vecs[NVEC-1].nonce, 32'd0));
    consume("wrap");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
